// File: rtl/snake_pkg.sv
// snake_pkg: NEC key codes, decoder state encoding and tick-window limits
// shared by the IR decoder and the game logic.
package snake_pkg;

    localparam logic [31:0] UP    = 32'h20DF6A95;
    localparam logic [31:0] DOWN  = 32'h20DFEA15;
    localparam logic [31:0] LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] RIGHT = 32'h20DF9A65;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } nec_state_t;

    localparam logic [10:0] CNT_MAX       = 11'd2047;
    localparam logic [10:0] LEAD_MARK_MIN = 11'd800;
    localparam logic [10:0] LEAD_MARK_MAX = 11'd1000;
    localparam logic [10:0] LEAD_DATA_MIN = 11'd400;
    localparam logic [10:0] LEAD_DATA_MAX = 11'd500;
    localparam logic [10:0] LEAD_RPT_MIN  = 11'd180;
    localparam logic [10:0] LEAD_RPT_MAX  = 11'd270;
    localparam logic [10:0] MARK_MIN      = 11'd40;
    localparam logic [10:0] MARK_MAX      = 11'd75;
    localparam logic [10:0] ZERO_MIN      = 11'd40;
    localparam logic [10:0] ZERO_MAX      = 11'd75;
    localparam logic [10:0] ONE_MIN       = 11'd140;
    localparam logic [10:0] ONE_MAX       = 11'd195;

    function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] hi);
        return v >= lo && v <= hi;
    endfunction

    // Bytes are MSB-first: byte0 = w[31:24] ... byte3 = w[7:0].
    function automatic logic frame_ok(input logic [31:0] w, input logic chk_addr);
        return (w[7:0] == ~w[15:8]) && (!chk_addr || w[23:16] == ~w[31:24]);
    endfunction

endpackage

// File: rtl/nec_ir_decoder_tick_gen.sv
// tick_gen: free-running prescaler, one-clk tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 500
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = cnt == W'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + W'(1);
        end

endmodule

// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: decodes NEC IR frames into a held 32-bit key code with
// one-clk valid / repeat_f / error pulses.
module nec_ir_decoder
    import snake_pkg::*;
#(
    parameter int TICK_DIV   = 500,
    parameter bit CHECK_ADDR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_in,
    output logic [31:0] code,
    output logic        valid,
    output logic        repeat_f,
    output logic        error
);
    logic        sync1, sync2, prev, tick, fall, rise, bit_one, bit_ok;
    logic [10:0] cnt;
    logic [31:0] shift, word;
    logic [4:0]  bitcnt;
    nec_state_t  state;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Reset to the idle-high level so releasing reset never looks like a fall.
    always_ff @(posedge clk or posedge reset)
        if (reset) {sync1, sync2, prev} <= 3'b111;
        else {sync1, sync2, prev} <= {ir_in, sync1, sync2};

    assign fall = prev & ~sync2;
    assign rise = ~prev & sync2;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (fall || rise) cnt <= '0;
        else if (tick && cnt != CNT_MAX) cnt <= cnt + 11'd1;

    assign bit_one = in_win(cnt, ONE_MIN, ONE_MAX);
    assign bit_ok  = bit_one || in_win(cnt, ZERO_MIN, ZERO_MAX);
    assign word    = {shift[30:0], bit_one};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bitcnt   <= '0;
            code     <= '0;
            valid    <= 1'b0;
            repeat_f <= 1'b0;
            error    <= 1'b0;
        end else begin
            valid    <= 1'b0;
            repeat_f <= 1'b0;
            error    <= 1'b0;
            case (state)
                IDLE: if (fall) state <= LEAD_MARK;
                LEAD_MARK:
                    if (rise && in_win(cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) state <= LEAD_SPACE;
                    else if (rise || cnt > LEAD_MARK_MAX) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end
                LEAD_SPACE:
                    if (fall && in_win(cnt, LEAD_DATA_MIN, LEAD_DATA_MAX)) begin
                        bitcnt <= '0;
                        state  <= BIT_MARK;
                    end else if (fall && in_win(cnt, LEAD_RPT_MIN, LEAD_RPT_MAX)) begin
                        repeat_f <= 1'b1;
                        state    <= STOP_MARK;
                    end else if (fall || cnt > LEAD_DATA_MAX) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end
                BIT_MARK:
                    if (rise && in_win(cnt, MARK_MIN, MARK_MAX)) state <= BIT_SPACE;
                    else if (rise || cnt > MARK_MAX) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end
                BIT_SPACE:
                    if (fall && bit_ok) begin
                        shift  <= word;
                        bitcnt <= bitcnt + 5'd1;
                        state  <= bitcnt == 5'd31 ? STOP_MARK : BIT_MARK;
                        if (bitcnt == 5'd31) begin
                            if (frame_ok(word, CHECK_ADDR)) begin
                                code  <= word;
                                valid <= 1'b1;
                            end else error <= 1'b1;
                        end
                    end else if (fall || cnt > ONE_MAX) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end
                STOP_MARK: if (rise || cnt > MARK_MAX) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

endmodule
